// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Two-requester lock arbiter in front of a single-port RAM.
//               A requester opens a lock with an address opcode, owns the RAM
//               until it closes with write-data or a completed read, and is
//               forcibly released after TIMEOUT idle cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [9:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [9:0] req1_data,
  output logic       req1_ready,
  output logic       rsp0_valid,
  output logic [7:0] rsp0_data,
  output logic       rsp1_valid,
  output logic [7:0] rsp1_data,
  output logic [9:0] ram_din,
  output logic       ram_rx_valid,
  input  logic [7:0] ram_dout,
  input  logic       ram_tx_valid,
  output logic       proto_err,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_OWN     = 2'd1,
    S_WAIT_RD = 2'd2
  } state_t;

  localparam logic [7:0] c_timer_max = 8'(TIMEOUT - 1);

  state_t     r_state;
  logic       r_owner;
  logic       r_last_grant;
  logic [7:0] r_timer;

  logic       w_xfer;
  logic       w_xfer_id;
  logic [9:0] w_word;
  logic [1:0] w_op;
  logic       w_opening;
  logic       w_expire;
  logic [7:0] w_timer_next;

  // Ready generation: round-robin on contention in IDLE, owner-only while locked.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        req0_ready = req0_valid & (~req1_valid | r_last_grant);
        req1_ready = req1_valid & (~req0_valid | ~r_last_grant);
      end
      S_OWN: begin
        req0_ready = ~r_owner;
        req1_ready = r_owner;
      end
      default: begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
      end
    endcase
  end

  // At most one ready is high, so the transfer source is unambiguous.
  assign w_xfer       = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign w_xfer_id    = req1_valid & req1_ready;
  assign w_word       = w_xfer_id ? req1_data : req0_data;
  assign w_op         = w_word[9:8];
  assign w_opening    = ~w_op[0];
  assign w_expire     = (r_timer == c_timer_max);
  // Timer holds at its ceiling rather than wrapping back to zero.
  assign w_timer_next = w_expire ? r_timer : r_timer + 8'd1;

  // Lock FSM with registered RAM command, response and error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_timer      <= 8'd0;
      ram_din      <= 10'd0;
      ram_rx_valid <= 1'b0;
      rsp0_valid   <= 1'b0;
      rsp0_data    <= 8'd0;
      rsp1_valid   <= 1'b0;
      rsp1_data    <= 8'd0;
      proto_err    <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      ram_rx_valid <= 1'b0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      proto_err    <= 1'b0;
      timeout_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            if (w_opening) begin
              ram_din      <= w_word;
              ram_rx_valid <= 1'b1;
              r_owner      <= w_xfer_id;
              r_last_grant <= w_xfer_id;
              r_timer      <= 8'd0;
              r_state      <= S_OWN;
            end else begin
              // Data opcode without an open lock: swallow it and flag.
              proto_err <= 1'b1;
            end
          end
        end
        S_OWN: begin
          if (w_xfer) begin
            ram_din      <= w_word;
            ram_rx_valid <= 1'b1;
            r_timer      <= 8'd0;
            case (w_op)
              2'b01:   r_state <= S_IDLE;
              2'b11:   r_state <= S_WAIT_RD;
              default: r_state <= S_OWN;
            endcase
          end else if (w_expire) begin
            r_state     <= S_IDLE;
            timeout_err <= 1'b1;
          end else begin
            r_timer <= w_timer_next;
          end
        end
        S_WAIT_RD: begin
          // A response arriving on the expiry cycle still completes the read.
          if (ram_tx_valid) begin
            if (r_owner) begin
              rsp1_valid <= 1'b1;
              rsp1_data  <= ram_dout;
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_data  <= ram_dout;
            end
            r_state <= S_IDLE;
          end else if (w_expire) begin
            r_state     <= S_IDLE;
            timeout_err <= 1'b1;
          end else begin
            r_timer <= w_timer_next;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Directed vector bench for ram_arbiter (TIMEOUT=4): contention,
//               write, read, protocol error, timeout, response/expiry race and
//               asynchronous reset during a read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [9:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_data, rsp1_data;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout;
  logic       ram_tx_valid;
  logic       proto_err, timeout_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       v0;
    logic [9:0] d0;
    logic       v1;
    logic [9:0] d1;
    logic       tx;
    logic [7:0] dout;
    logic       e_rdy0;
    logic       e_rdy1;
    logic       e_rxv;
    logic [9:0] e_din;
    logic       e_r0v;
    logic       e_r1v;
    logic [7:0] e_rdata;
    logic       e_perr;
    logic       e_terr;
  } vec_t;

  vec_t vecs[$];

  ram_arbiter #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .rsp0_valid   (rsp0_valid),
    .rsp0_data    (rsp0_data),
    .rsp1_valid   (rsp1_valid),
    .rsp1_data    (rsp1_data),
    .ram_din      (ram_din),
    .ram_rx_valid (ram_rx_valid),
    .ram_dout     (ram_dout),
    .ram_tx_valid (ram_tx_valid),
    .proto_err    (proto_err),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v0, input logic [9:0] d0, input logic v1, input logic [9:0] d1,
                     input logic tx, input logic [7:0] dout, input logic r0, input logic r1,
                     input logic rxv, input logic [9:0] din, input logic s0, input logic s1,
                     input logic [7:0] sd, input logic pe, input logic te);
    vec_t v;
    v = '{v0, d0, v1, d1, tx, dout, r0, r1, rxv, din, s0, s1, sd, pe, te};
    vecs.push_back(v);
  endtask

  // Called at a negedge: drive inputs, check readies, clock, check registered outputs.
  task automatic apply(input vec_t v, input string tag);
    req0_valid   = v.v0;
    req0_data    = v.d0;
    req1_valid   = v.v1;
    req1_data    = v.d1;
    ram_tx_valid = v.tx;
    ram_dout     = v.dout;
    #1;
    chk({tag, " ready0"}, 32'(req0_ready), 32'(v.e_rdy0));
    chk({tag, " ready1"}, 32'(req1_ready), 32'(v.e_rdy1));
    @(posedge clk);
    @(negedge clk);
    chk({tag, " ram_rx_valid"}, 32'(ram_rx_valid), 32'(v.e_rxv));
    if (v.e_rxv) chk({tag, " ram_din"}, 32'(ram_din), 32'(v.e_din));
    chk({tag, " rsp0_valid"}, 32'(rsp0_valid), 32'(v.e_r0v));
    chk({tag, " rsp1_valid"}, 32'(rsp1_valid), 32'(v.e_r1v));
    if (v.e_r0v) chk({tag, " rsp0_data"}, 32'(rsp0_data), 32'(v.e_rdata));
    if (v.e_r1v) chk({tag, " rsp1_data"}, 32'(rsp1_data), 32'(v.e_rdata));
    chk({tag, " proto_err"}, 32'(proto_err), 32'(v.e_perr));
    chk({tag, " timeout_err"}, 32'(timeout_err), 32'(v.e_terr));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " ram_din"}, 32'(ram_din), 32'h0);
    chk({tag, " ram_rx_valid"}, 32'(ram_rx_valid), 32'h0);
    chk({tag, " rsp0_valid"}, 32'(rsp0_valid), 32'h0);
    chk({tag, " rsp1_valid"}, 32'(rsp1_valid), 32'h0);
    chk({tag, " rsp0_data"}, 32'(rsp0_data), 32'h0);
    chk({tag, " rsp1_data"}, 32'(rsp1_data), 32'h0);
    chk({tag, " proto_err"}, 32'(proto_err), 32'h0);
    chk({tag, " timeout_err"}, 32'(timeout_err), 32'h0);
  endtask

  initial begin
    vec_t h;
    rst_n        = 1'b0;
    req0_valid   = 1'b0;
    req0_data    = 10'h0;
    req1_valid   = 1'b0;
    req1_data    = 10'h0;
    ram_tx_valid = 1'b0;
    ram_dout     = 8'h0;

    //   v0 d0       v1 d1       tx dout    rdy0 rdy1 rxv din      r0v r1v data   pe te
    // Contention from reset: req0 first, then alternate
    add(1, 10'h011, 1, 10'h022, 0, 8'h00,  1, 0,  1, 10'h011,  0, 0, 8'h00,  0, 0);
    add(1, 10'h1A1, 1, 10'h022, 0, 8'h00,  1, 0,  1, 10'h1A1,  0, 0, 8'h00,  0, 0);
    add(1, 10'h012, 1, 10'h022, 0, 8'h00,  0, 1,  1, 10'h022,  0, 0, 8'h00,  0, 0);
    add(1, 10'h012, 1, 10'h1B2, 0, 8'h00,  0, 1,  1, 10'h1B2,  0, 0, 8'h00,  0, 0);
    add(1, 10'h012, 1, 10'h023, 0, 8'h00,  1, 0,  1, 10'h012,  0, 0, 8'h00,  0, 0);
    add(1, 10'h1A3, 1, 10'h023, 0, 8'h00,  1, 0,  1, 10'h1A3,  0, 0, 8'h00,  0, 0);
    add(0, 10'h000, 0, 10'h000, 0, 8'h00,  0, 0,  0, 10'h000,  0, 0, 8'h00,  0, 0);
    // Write by req0
    add(1, 10'h005, 0, 10'h000, 0, 8'h00,  1, 0,  1, 10'h005,  0, 0, 8'h00,  0, 0);
    add(1, 10'h1AA, 0, 10'h000, 0, 8'h00,  1, 0,  1, 10'h1AA,  0, 0, 8'h00,  0, 0);
    add(0, 10'h000, 0, 10'h000, 0, 8'h00,  0, 0,  0, 10'h000,  0, 0, 8'h00,  0, 0);
    // Read by req1, RAM answers 3 cycles after the read-data word
    add(0, 10'h000, 1, 10'h207, 0, 8'h00,  0, 1,  1, 10'h207,  0, 0, 8'h00,  0, 0);
    add(0, 10'h000, 1, 10'h300, 0, 8'h00,  0, 1,  1, 10'h300,  0, 0, 8'h00,  0, 0);
    add(1, 10'h005, 0, 10'h000, 0, 8'h00,  0, 0,  0, 10'h000,  0, 0, 8'h00,  0, 0);
    add(1, 10'h005, 0, 10'h000, 0, 8'h00,  0, 0,  0, 10'h000,  0, 0, 8'h00,  0, 0);
    add(0, 10'h000, 0, 10'h000, 1, 8'h5C,  0, 0,  0, 10'h000,  0, 1, 8'h5C,  0, 0);
    add(0, 10'h000, 0, 10'h000, 0, 8'h00,  0, 0,  0, 10'h000,  0, 0, 8'h00,  0, 0);
    // Protocol error from IDLE
    add(1, 10'h1FF, 0, 10'h000, 0, 8'h00,  1, 0,  0, 10'h000,  0, 0, 8'h00,  1, 0);
    add(0, 10'h000, 0, 10'h000, 0, 8'h00,  0, 0,  0, 10'h000,  0, 0, 8'h00,  0, 0);
    // Timeout: req0 opens and goes silent while req1 waits
    add(1, 10'h010, 0, 10'h000, 0, 8'h00,  1, 0,  1, 10'h010,  0, 0, 8'h00,  0, 0);
    add(0, 10'h000, 1, 10'h220, 0, 8'h00,  1, 0,  0, 10'h000,  0, 0, 8'h00,  0, 0);
    add(0, 10'h000, 1, 10'h220, 0, 8'h00,  1, 0,  0, 10'h000,  0, 0, 8'h00,  0, 0);
    add(0, 10'h000, 1, 10'h220, 0, 8'h00,  1, 0,  0, 10'h000,  0, 0, 8'h00,  0, 0);
    add(0, 10'h000, 1, 10'h220, 0, 8'h00,  1, 0,  0, 10'h000,  0, 0, 8'h00,  0, 1);
    add(0, 10'h000, 1, 10'h220, 0, 8'h00,  0, 1,  1, 10'h220,  0, 0, 8'h00,  0, 0);
    add(0, 10'h000, 1, 10'h1BB, 0, 8'h00,  0, 1,  1, 10'h1BB,  0, 0, 8'h00,  0, 0);
    add(0, 10'h000, 0, 10'h000, 0, 8'h00,  0, 0,  0, 10'h000,  0, 0, 8'h00,  0, 0);
    // Response arrives exactly at timer expiry: response wins
    add(1, 10'h233, 0, 10'h000, 0, 8'h00,  1, 0,  1, 10'h233,  0, 0, 8'h00,  0, 0);
    add(1, 10'h3FF, 0, 10'h000, 0, 8'h00,  1, 0,  1, 10'h3FF,  0, 0, 8'h00,  0, 0);
    add(0, 10'h000, 0, 10'h000, 0, 8'h00,  0, 0,  0, 10'h000,  0, 0, 8'h00,  0, 0);
    add(0, 10'h000, 0, 10'h000, 0, 8'h00,  0, 0,  0, 10'h000,  0, 0, 8'h00,  0, 0);
    add(0, 10'h000, 0, 10'h000, 0, 8'h00,  0, 0,  0, 10'h000,  0, 0, 8'h00,  0, 0);
    add(0, 10'h000, 0, 10'h000, 1, 8'hA5,  0, 0,  0, 10'h000,  1, 0, 8'hA5,  0, 0);
    // Stray ram_tx_valid in IDLE is ignored
    add(0, 10'h000, 0, 10'h000, 1, 8'h77,  0, 0,  0, 10'h000,  0, 0, 8'h00,  0, 0);
    add(0, 10'h000, 0, 10'h000, 0, 8'h00,  0, 0,  0, 10'h000,  0, 0, 8'h00,  0, 0);

    // Reset state
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted during WAIT_RD abandons the read
    h = '{0, 10'h000, 1, 10'h207, 0, 8'h00, 0, 1, 1, 10'h207, 0, 0, 8'h00, 0, 0};
    apply(h, "rd_addr");
    h = '{0, 10'h000, 1, 10'h300, 0, 8'h00, 0, 1, 1, 10'h300, 0, 0, 8'h00, 0, 0};
    apply(h, "rd_data");
    req1_valid = 1'b0;
    rst_n      = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    h = '{0, 10'h000, 0, 10'h000, 1, 8'h99, 0, 0, 0, 10'h000, 0, 0, 8'h00, 0, 0};
    apply(h, "late_tx");
    h = '{1, 10'h005, 0, 10'h000, 0, 8'h00, 1, 0, 1, 10'h005, 0, 0, 8'h00, 0, 0};
    apply(h, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
